// File: rtl/grid_pkg.sv
// Shared types and helpers for the sequential grid solver: default geometry,
// FSM encoding, block numbering and candidate selection.
package grid_pkg;

  localparam int ORD   = 3;
  localparam int LEN   = ORD * ORD;
  localparam int AREA  = LEN * LEN;
  localparam int IDX_W = $clog2(AREA);

  // Working width for candidate arithmetic; covers grid orders up to 5.
  localparam int MAXW = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic int blockof(input int r, input int c, input int ord);
    return (r / ord) * ord + (c / ord);
  endfunction

  // Lowest clear bit of mask strictly above the one-hot cur (anywhere if cur == 0).
  function automatic logic [MAXW-1:0] lowest_bit_above(input logic [MAXW-1:0] mask,
                                                       input logic [MAXW-1:0] cur);
    logic [MAXW-1:0] above;
    logic [MAXW-1:0] free;
    above = (cur == '0) ? '1 : ~((cur << 1) - 1'b1);
    free  = above & ~mask;
    return free & (~free + 1'b1);
  endfunction

endpackage

// File: rtl/grid_occupancy.sv
// Combinational row/column/block occupancy for the search cell and the load cell.
// Zero latency; purely a function of the current cell contents.
module grid_occupancy #(
  parameter  int ORD   = 3,
  localparam int LEN   = ORD * ORD,
  localparam int AREA  = LEN * LEN,
  localparam int IDX_W = $clog2(AREA)
) (
  input  logic [AREA*LEN-1:0] cells,
  input  logic [IDX_W-1:0]    ptr_idx,
  input  logic [IDX_W-1:0]    load_idx,
  output logic [LEN-1:0]      ptr_mask,
  output logic [LEN-1:0]      load_mask
);
  import grid_pkg::*;

  logic [LEN-1:0] row_or [LEN];
  logic [LEN-1:0] col_or [LEN];
  logic [LEN-1:0] blk_or [LEN];

  for (genvar g = 0; g < LEN; g++) begin : g_grp
    logic [LEN-1:0] row_m;
    logic [LEN-1:0] col_m;
    logic [LEN-1:0] blk_m;

    always_comb begin
      row_m = '0;
      col_m = '0;
      blk_m = '0;
      for (int k = 0; k < LEN; k++) begin
        row_m = row_m | cells[(g * LEN + k) * LEN +: LEN];
        col_m = col_m | cells[(k * LEN + g) * LEN +: LEN];
        blk_m = blk_m | cells[(((g / ORD) * ORD + k / ORD) * LEN
                               + (g % ORD) * ORD + k % ORD) * LEN +: LEN];
      end
    end

    assign row_or[g] = row_m;
    assign col_or[g] = col_m;
    assign blk_or[g] = blk_m;
  end

  always_comb begin
    int pr;
    int pc;
    int lr;
    int lc;
    pr = int'(ptr_idx) / LEN;
    pc = int'(ptr_idx) % LEN;
    lr = int'(load_idx) / LEN;
    lc = int'(load_idx) % LEN;
    ptr_mask  = '0;
    load_mask = '0;
    for (int g = 0; g < LEN; g++) begin
      if (g == pr)                  ptr_mask  = ptr_mask  | row_or[g];
      if (g == pc)                  ptr_mask  = ptr_mask  | col_or[g];
      if (g == blockof(pr, pc, ORD)) ptr_mask  = ptr_mask  | blk_or[g];
      if (g == lr)                  load_mask = load_mask | row_or[g];
      if (g == lc)                  load_mask = load_mask | col_or[g];
      if (g == blockof(lr, lc, ORD)) load_mask = load_mask | blk_or[g];
    end
  end

endmodule

// File: rtl/grid_seq_solver.sv
// Backtracking sudoku solver: serial given preload, one cell step per cycle,
// solution counting with first-solution capture; readback has 1-cycle latency.
module grid_seq_solver #(
  parameter  int ORD       = 3,
  parameter  int MAX_SOLNS = 2,
  parameter  int CYC_W     = 32,
  localparam int LEN       = ORD * ORD,
  localparam int AREA      = LEN * LEN,
  localparam int IDX_W     = $clog2(AREA),
  localparam int SC_W      = $clog2(MAX_SOLNS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_valid,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [LEN-1:0]   load_val,
  input  logic             start,
  input  logic [CYC_W-1:0] timeout_cycles,
  output logic             busy,
  output logic             done,
  output logic [SC_W-1:0]  soln_count,
  output logic             timed_out,
  output logic             bad_load,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [LEN-1:0]   rd_val
);
  import grid_pkg::*;

  localparam logic [IDX_W-1:0] LAST     = IDX_W'(AREA - 1);
  localparam logic             DIR_FWD  = 1'b0;
  localparam logic             DIR_BACK = 1'b1;

  logic [LEN-1:0]   val_q  [AREA];
  logic [LEN-1:0]   val_d  [AREA];
  logic [LEN-1:0]   snap_q [AREA];
  logic [LEN-1:0]   snap_d [AREA];
  logic [AREA-1:0]  fixed_q, fixed_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             dir_q, dir_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  state_t           state_q, state_d;
  logic [SC_W-1:0]  soln_q, soln_d;
  logic             timed_out_q, timed_out_d;
  logic             bad_load_q, bad_load_d;
  logic [LEN-1:0]   rd_val_q, rd_val_d;

  logic [AREA*LEN-1:0] cells_flat;
  logic [LEN-1:0]      ptr_mask;
  logic [LEN-1:0]      load_mask;
  logic [LEN-1:0]      cand;
  logic                load_ok;
  logic                sol;
  logic                exh;

  for (genvar i = 0; i < AREA; i++) begin : g_flat
    assign cells_flat[i*LEN +: LEN] = val_q[i];
  end

  grid_occupancy #(
    .ORD (ORD)
  ) u_occ (
    .cells     (cells_flat),
    .ptr_idx   (ptr_q),
    .load_idx  (load_idx),
    .ptr_mask  (ptr_mask),
    .load_mask (load_mask)
  );

  always_comb begin
    val_d       = val_q;
    snap_d      = snap_q;
    fixed_d     = fixed_q;
    ptr_d       = ptr_q;
    dir_d       = dir_q;
    cyc_d       = cyc_q;
    state_d     = state_q;
    soln_d      = soln_q;
    timed_out_d = timed_out_q;
    bad_load_d  = bad_load_q;
    rd_val_d    = (int'(rd_idx) < AREA) ? snap_q[rd_idx] : '0;
    sol         = 1'b0;
    exh         = 1'b0;
    // Bits above LEN are forced "used" so a candidate never escapes the digit range.
    cand = LEN'(lowest_bit_above({{(MAXW - LEN){1'b1}}, ptr_mask},
                                 {{(MAXW - LEN){1'b0}}, val_q[ptr_q]}));
    load_ok = (int'(load_idx) < AREA)
              && ((load_val & (load_val - 1'b1)) == '0)
              && ((load_val & load_mask & ~val_q[load_idx]) == '0);

    if (clear) begin
      for (int i = 0; i < AREA; i++) begin
        val_d[i]  = '0;
        snap_d[i] = '0;
      end
      fixed_d     = '0;
      ptr_d       = '0;
      dir_d       = DIR_FWD;
      cyc_d       = '0;
      soln_d      = '0;
      timed_out_d = 1'b0;
      bad_load_d  = 1'b0;
      rd_val_d    = '0;
      state_d     = ST_IDLE;
    end else if (start && state_q != ST_SEARCH) begin
      for (int i = 0; i < AREA; i++) snap_d[i] = '0;
      soln_d      = '0;
      timed_out_d = 1'b0;
      if (bad_load_q) begin
        state_d = ST_DONE;
      end else begin
        for (int i = 0; i < AREA; i++) begin
          if (!fixed_q[i]) val_d[i] = '0;
        end
        ptr_d   = '0;
        dir_d   = DIR_FWD;
        cyc_d   = '0;
        state_d = ST_SEARCH;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_valid) begin
            if (load_ok) begin
              val_d[load_idx]   = load_val;
              fixed_d[load_idx] = |load_val;
            end else begin
              bad_load_d = 1'b1;
            end
          end
        end

        ST_SEARCH: begin
          cyc_d = cyc_q + 1'b1;
          if (fixed_q[ptr_q]) begin
            if (dir_q == DIR_FWD) begin
              if (ptr_q == LAST) sol = 1'b1;
              else               ptr_d = ptr_q + 1'b1;
            end else begin
              if (ptr_q == '0) exh = 1'b1;
              else             ptr_d = ptr_q - 1'b1;
            end
          end else if (cand != '0) begin
            val_d[ptr_q] = cand;
            dir_d        = DIR_FWD;
            if (ptr_q == LAST) sol = 1'b1;
            else               ptr_d = ptr_q + 1'b1;
          end else begin
            val_d[ptr_q] = '0;
            dir_d        = DIR_BACK;
            if (ptr_q == '0) exh = 1'b1;
            else             ptr_d = ptr_q - 1'b1;
          end

          // Below the limit, a solution reopens the last cell to hunt for the next one.
          if (sol) begin
            soln_d = soln_q + 1'b1;
            if (soln_q == '0) snap_d = val_d;
            if (soln_d == SC_W'(MAX_SOLNS)) begin
              state_d = ST_DONE;
            end else begin
              dir_d = DIR_BACK;
              ptr_d = LAST;
            end
          end
          if (exh) state_d = ST_DONE;
          if (timeout_cycles != '0 && cyc_q == timeout_cycles - 1'b1) begin
            state_d     = ST_DONE;
            timed_out_d = 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < AREA; i++) begin
        val_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      fixed_q     <= '0;
      ptr_q       <= '0;
      dir_q       <= DIR_FWD;
      cyc_q       <= '0;
      state_q     <= ST_IDLE;
      soln_q      <= '0;
      timed_out_q <= 1'b0;
      bad_load_q  <= 1'b0;
      rd_val_q    <= '0;
    end else begin
      val_q       <= val_d;
      snap_q      <= snap_d;
      fixed_q     <= fixed_d;
      ptr_q       <= ptr_d;
      dir_q       <= dir_d;
      cyc_q       <= cyc_d;
      state_q     <= state_d;
      soln_q      <= soln_d;
      timed_out_q <= timed_out_d;
      bad_load_q  <= bad_load_d;
      rd_val_q    <= rd_val_d;
    end
  end

  assign busy       = (state_q == ST_SEARCH);
  assign done       = (state_q == ST_DONE);
  assign soln_count = soln_q;
  assign timed_out  = timed_out_q;
  assign bad_load   = bad_load_q;
  assign rd_val     = rd_val_q;

endmodule

// File: tb/tb_grid_seq_solver.sv
// Directed bench: two 4x4 solvers (limits 1 and 2) share stimulus, a 9x9 solver covers timeout and reset.
module tb_grid_seq_solver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;

  logic        ld_vld = 1'b0;
  logic [3:0]  ld_idx = '0;
  logic [3:0]  ld_val = '0;
  logic        start = 1'b0;
  logic [31:0] tmo = '0;
  logic [3:0]  rd_idx = '0;

  logic        busy1, done1, to1, bad1;
  logic [0:0]  cnt1;
  logic [3:0]  rdv1;
  logic        busy2, done2, to2, bad2;
  logic [1:0]  cnt2;
  logic [3:0]  rdv2;

  logic        ld_vld3 = 1'b0;
  logic [6:0]  ld_idx3 = '0;
  logic [8:0]  ld_val3 = '0;
  logic        start3 = 1'b0;
  logic [31:0] tmo3 = '0;
  logic [6:0]  rd_idx3 = '0;
  logic        busy3, done3, to3, bad3;
  logic [1:0]  cnt3;
  logic [8:0]  rdv3;

  int n_tests = 0;
  int n_fail  = 0;
  int sol_tab [16] = '{1, 2, 3, 4, 3, 4, 1, 2, 2, 1, 4, 3, 4, 3, 2, 1};

  always #5 clock = ~clock;

  grid_seq_solver #(.ORD(2), .MAX_SOLNS(1), .CYC_W(32)) u1 (
    .clock(clock), .reset(reset), .clear(clear), .load_valid(ld_vld),
    .load_idx(ld_idx), .load_val(ld_val), .start(start), .timeout_cycles(tmo),
    .busy(busy1), .done(done1), .soln_count(cnt1), .timed_out(to1),
    .bad_load(bad1), .rd_idx(rd_idx), .rd_val(rdv1));

  grid_seq_solver #(.ORD(2), .MAX_SOLNS(2), .CYC_W(32)) u2 (
    .clock(clock), .reset(reset), .clear(clear), .load_valid(ld_vld),
    .load_idx(ld_idx), .load_val(ld_val), .start(start), .timeout_cycles(tmo),
    .busy(busy2), .done(done2), .soln_count(cnt2), .timed_out(to2),
    .bad_load(bad2), .rd_idx(rd_idx), .rd_val(rdv2));

  grid_seq_solver #(.ORD(3), .MAX_SOLNS(2), .CYC_W(32)) u3 (
    .clock(clock), .reset(reset), .clear(clear), .load_valid(ld_vld3),
    .load_idx(ld_idx3), .load_val(ld_val3), .start(start3), .timeout_cycles(tmo3),
    .busy(busy3), .done(done3), .soln_count(cnt3), .timed_out(to3),
    .bad_load(bad3), .rd_idx(rd_idx3), .rd_val(rdv3));

  function automatic logic [3:0] oh(input int d);
    logic [3:0] v;
    v = (d == 0) ? 4'b0000 : 4'(1 << (d - 1));
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load2(input int idx, input int d);
    ld_vld = 1'b1;
    ld_idx = 4'(idx);
    ld_val = oh(d);
    tick();
    ld_vld = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_tests++;
    if ({busy1, done1, cnt1, to1, bad1} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_u1_status: got %b expected 00000", {busy1, done1, cnt1, to1, bad1});
    end
    n_tests++;
    if ({busy2, done2, cnt2, to2, bad2} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_u2_status: got %b expected 000000", {busy2, done2, cnt2, to2, bad2});
    end
    n_tests++;
    if ({busy3, done3, cnt3, to3, bad3} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_u3_status: got %b expected 000000", {busy3, done3, cnt3, to3, bad3});
    end
    n_tests++;
    if (rdv1 !== 4'b0 || rdv3 !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_rd_val: got %h/%h expected 0/0", rdv1, rdv3);
    end
  endtask

  task automatic test_empty_grid();
    int cycles;
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    while (busy1 && cycles < 1000) begin
      tick();
      cycles++;
    end
    n_tests++;
    if (cycles !== 16) begin
      n_fail++;
      $display("FAIL empty_u1_search_cycles: got %0d expected 16", cycles);
    end
    n_tests++;
    if ({done1, cnt1, to1} !== 3'b110) begin
      n_fail++;
      $display("FAIL empty_u1_result: got done/cnt/to=%b expected 110", {done1, cnt1, to1});
    end
    cycles = 0;
    while (!done2 && cycles < 5000) begin
      tick();
      cycles++;
    end
    n_tests++;
    if (!done2) begin
      n_fail++;
      $display("FAIL empty_u2_done: got done=0 after %0d cycles expected 1", cycles);
    end
    n_tests++;
    if (cnt2 !== 2'd2 || to2 !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_u2_count: got cnt=%0d to=%b expected cnt=2 to=0", cnt2, to2);
    end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      tick();
      n_tests++;
      if (rdv1 !== oh(sol_tab[i])) begin
        n_fail++;
        $display("FAIL empty_u1_snap[%0d]: got %b expected %b", i, rdv1, oh(sol_tab[i]));
      end
      n_tests++;
      if (rdv2 !== oh(sol_tab[i])) begin
        n_fail++;
        $display("FAIL empty_u2_snap[%0d]: got %b expected %b", i, rdv2, oh(sol_tab[i]));
      end
    end
  endtask

  task automatic test_givens_unique();
    int cycles;
    do_clear();
    for (int i = 0; i < 16; i++) begin
      if (i != 0 && i != 5 && i != 15) load2(i, sol_tab[i]);
    end
    n_tests++;
    if (bad2 !== 1'b0) begin
      n_fail++;
      $display("FAIL givens_bad_load: got %b expected 0", bad2);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    while (!done2 && cycles < 5000) begin
      tick();
      cycles++;
    end
    n_tests++;
    if (!done2 || cnt2 !== 2'd1 || to2 !== 1'b0) begin
      n_fail++;
      $display("FAIL givens_u2_result: got done=%b cnt=%0d to=%b expected 1/1/0", done2, cnt2, to2);
    end
    n_tests++;
    if (!done1 || cnt1 !== 1'b1) begin
      n_fail++;
      $display("FAIL givens_u1_result: got done=%b cnt=%0d expected 1/1", done1, cnt1);
    end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      tick();
      n_tests++;
      if (rdv2 !== oh(sol_tab[i])) begin
        n_fail++;
        $display("FAIL givens_snap[%0d]: got %b expected %b", i, rdv2, oh(sol_tab[i]));
      end
    end
  endtask

  task automatic test_bad_load();
    do_clear();
    load2(0, 1);
    n_tests++;
    if (bad2 !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_load_first_ok: got %b expected 0", bad2);
    end
    load2(1, 1);
    n_tests++;
    if (bad1 !== 1'b1 || bad2 !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_load_flag: got %b%b expected 11", bad1, bad2);
    end
    n_tests++;
    if (u2.val_q[1] !== 4'b0) begin
      n_fail++;
      $display("FAIL bad_load_cell1: got %b expected 0000", u2.val_q[1]);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if ({done2, busy2, cnt2} !== 4'b1000) begin
      n_fail++;
      $display("FAIL bad_load_start: got done/busy/cnt=%b expected 1000", {done2, busy2, cnt2});
    end
    do_clear();
    n_tests++;
    if ({bad2, done2, bad1, done1} !== 4'b0) begin
      n_fail++;
      $display("FAIL bad_load_clear: got %b expected 0000", {bad2, done2, bad1, done1});
    end
  endtask

  task automatic test_exhausted();
    int cycles;
    do_clear();
    load2(0, 1);
    load2(1, 2);
    load2(10, 3);
    load2(14, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    while (!done2 && cycles < 5000) begin
      tick();
      cycles++;
    end
    n_tests++;
    if (!done2 || cnt2 !== 2'd0 || to2 !== 1'b0 || bad2 !== 1'b0) begin
      n_fail++;
      $display("FAIL exhausted_u2: got done=%b cnt=%0d to=%b bad=%b expected 1/0/0/0",
               done2, cnt2, to2, bad2);
    end
    n_tests++;
    if (!done1 || cnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL exhausted_u1: got done=%b cnt=%0d expected 1/0", done1, cnt1);
    end
  endtask

  task automatic test_timeout();
    int cycles;
    tmo3 = 32'd5;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    cycles = 0;
    while (busy3 && cycles < 1000) begin
      tick();
      cycles++;
    end
    n_tests++;
    if (cycles !== 5) begin
      n_fail++;
      $display("FAIL timeout_cycles: got %0d expected 5", cycles);
    end
    n_tests++;
    if ({done3, to3, cnt3} !== 4'b1100) begin
      n_fail++;
      $display("FAIL timeout_result: got done/to/cnt=%b expected 1100", {done3, to3, cnt3});
    end
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick();
    n_tests++;
    if (busy3 !== 1'b1 || to3 !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_restart: got busy=%b to=%b expected 1/0", busy3, to3);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if ({busy3, done3, to3, cnt3, bad3} !== 6'b0 || rdv3 !== 9'b0) begin
      n_fail++;
      $display("FAIL timeout_mid_reset: got status=%b rd=%h expected 000000/0",
               {busy3, done3, to3, cnt3, bad3}, rdv3);
    end
  endtask

  initial begin
    test_reset();
    test_empty_grid();
    test_givens_unique();
    test_bad_load();
    test_exhausted();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_seq_solver.md
Name: grid_seq_solver

Overview:
- Parametrised, sequential backtracking sudoku solver; successor to the fixed-size tile-network grid.
- Grid order is a parameter. Givens are preloaded serially, and given cells are skipped during search.
- Counts solutions up to a limit (none/unique/multiple), captures the first solution for readback, and supports a cycle-budget timeout.
- Sits beside the grid as a standalone solve engine; host-facing load/readback ports.

Parameters:
- ORD, 3: grid order; LEN = ORD*ORD, AREA = LEN*LEN.
- MAX_SOLNS, 2: stop after this many solutions found (>=1).
- CYC_W, 32: width of the timeout budget and cycle counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  zero all cells and given flags; clear bad_load; go to IDLE
- load_valid  in  1  write a given (accepted in IDLE only)
- load_idx  in  IDX_W=$clog2(AREA)  row-major cell index
- load_val  in  LEN  one-hot value (bit k-1 = digit k); zero = un-give the cell
- start  in  1  begin search (accepted in IDLE or DONE)
- timeout_cycles  in  CYC_W  search-cycle budget; 0 = unlimited
- busy  out  1  high in SEARCH
- done  out  1  high in DONE
- soln_count  out  $clog2(MAX_SOLNS+1)  solutions found
- timed_out  out  1  search ended by budget
- bad_load  out  1  sticky: a rejected load occurred
- rd_idx  in  IDX_W  readback cell index
- rd_val  out  LEN  first captured solution at rd_idx; 1-cycle latency

Behaviour:
- State: val[AREA] (LEN-bit one-hot or 0), fixed[AREA], snap[AREA], ptr (0..AREA-1), dir (fwd/back), cyc counter, FSM {IDLE, SEARCH, DONE}.
- Masks: row/col/blk masks are the combinational OR of val over each group.
- Reset: all registers 0, FSM=IDLE, so busy=done=timed_out=bad_load=0, soln_count=0, rd_val=0 on the following cycle.
- Priority each cycle: reset > clear > start > load.
- Load (IDLE only):
  - Reject if load_val is nonzero and not one-hot.
  - Reject if |(load_val & (rowmask|colmask|blkmask) & ~val[idx]).
  - A rejected load sets bad_load and leaves the cell unchanged.
  - An accepted load sets val[idx]=load_val and fixed[idx]=|load_val.
  - Loads outside IDLE are ignored, with no flag.
- Start:
  - Next cycle: non-fixed cells zeroed, ptr=0, dir=fwd, cyc=0, soln_count=0, snap zeroed, timed_out=0, FSM=SEARCH.
  - start while SEARCH is ignored.
  - start while bad_load=1 goes directly to DONE with soln_count=0.
- SEARCH, one cell step per cycle, cyc increments:
  - fixed[ptr]: ptr moves one step in dir.
  - Otherwise, cand = lowest zero bit of masks strictly above val[ptr] (any bit if val[ptr]=0).
    - cand exists: val[ptr]=cand, dir=fwd, ptr+1.
    - No cand: val[ptr]=0, dir=back, ptr-1.
  - Forward step past AREA-1 means a solution:
    - soln_count+1; snap=val if this is the first solution.
    - If the new count == MAX_SOLNS, go to DONE.
    - Otherwise dir=back, ptr=AREA-1 (retry the last non-fixed cell with a higher value).
  - Backward step below 0 means exhausted: DONE.
  - timeout_cycles!=0 and cyc==timeout_cycles-1 at a step: go to DONE after this step, timed_out=1. A solution event on the same cycle is still counted.
- DONE: outputs held until start, clear or reset. clear in DONE or SEARCH aborts to IDLE and zeroes outputs.
- Readback: rd_val is registered: rd_val <= snap[rd_idx]. It is valid in any state and is zero for out-of-range rd_idx.

Decomposition:
- Package grid_pkg: ORD-derived localparams LEN, AREA, IDX_W; function blockof(r,c); typedef for the FSM enum; function lowest_bit_above(mask, cur).
- One sub-module: grid_occupancy, the combinational row/col/blk mask builder for the cell at ptr and at load_idx. Everything else stays in grid_seq_solver.

Test Plan:
- ORD=2, MAX_SOLNS=1, empty grid, start -> done, soln_count=1, timed_out=0; readback rows 1234/3412/2143/4321, after exactly 16 search cycles.
- ORD=2, MAX_SOLNS=2, empty grid -> soln_count=2, snap = the same 1234/3412/2143/4321 grid.
- ORD=2, MAX_SOLNS=2, givens = that solution with cells 0,5,15 blank -> soln_count=1, snap equals the full solution.
- ORD=2: load cell0=1, then cell1=1 -> bad_load=1, cell1 stays 0; a subsequent start -> done next cycle, soln_count=0; clear -> bad_load=0.
- ORD=2, givens cell0=1, cell1=2, cell10=3, cell14=4 -> exhausted: done, soln_count=0, timed_out=0.
- ORD=3, empty grid, timeout_cycles=5 -> done after exactly 5 search cycles, timed_out=1, soln_count=0. A repeat with reset asserted mid-SEARCH -> all outputs 0 the following cycle, FSM=IDLE.
